mult_share_ctrl: RTL and testbench
==================================

Name: mult_share_ctrl

Overview:
- Time-shares one pipelined_multiplier instance between NREQ requesters.
- Each requester has a valid/ready operand port and a valid/ready result port.
- The block arbitrates round-robin, drives the operand bus and the multiplier stage enable, and carries a requester tag alongside each operation.
- When a result is not accepted, the block stalls the whole multiplier pipeline and issues no new grants.

Parameters:
- WIDTH, 32: operand width; product width is 2*WIDTH.
- NREQ, 2: number of requesters (2..8).
- LAT, 1: multiplier register stages, i.e. cycles from operand issue to product valid.
- TW, 3: tag width; requires 2**TW >= NREQ.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  bit i: requester i presents operands.
- req_ready  out  NREQ  bit i: requester i's operands accepted this cycle.
- req_mcand  in  NREQ*WIDTH  requester i's multiplicand in slice [i*WIDTH +: WIDTH].
- req_mplier  in  NREQ*WIDTH  requester i's multiplier in slice [i*WIDTH +: WIDTH].
- mul_en  out  1  stage enable to the multiplier.
- mul_mcand  out  WIDTH  multiplicand to the multiplier.
- mul_mplier  out  WIDTH  multiplier operand to the multiplier.
- mul_product  in  2*WIDTH  product from the multiplier.
- res_valid  out  NREQ  bit i: result for requester i is on res_product.
- res_ready  in  NREQ  bit i: requester i accepts its result.
- res_product  out  2*WIDTH  result data, shared by all requesters.
- idle  out  1  high when no operation is in flight.

Behaviour:
- Pipeline tracking
  - Shift registers vld[0..LAT-1] and tag[0..LAT-1].
  - Stage LAT-1 is the output stage.
- Stall and advance
  - stall = vld[LAT-1] && !res_ready[tag[LAT-1]].
  - adv = !stall.
  - mul_en = adv, combinational.
  - On a rising edge with adv=1: vld[0] <= (a grant occurred), tag[0] <= granted index, and stages k>0 shift from k-1.
  - On a rising edge with adv=0: all stages hold.
- Arbitration (combinational each cycle)
  - When adv=1, grant the first i with req_valid[i]=1, searching from ptr upward and wrapping modulo NREQ.
  - req_ready is one-hot for the grant; it is all-zero when there is no grant or when stalled.
  - mul_mcand and mul_mplier mux the granted requester's slices; both are zero when there is no grant.
  - On a clock edge with a grant to g: ptr <= (g+1) mod NREQ. With no grant, ptr holds.
- Result path
  - res_valid[i] = vld[LAT-1] && (tag[LAT-1]==i).
  - res_product = mul_product when vld[LAT-1]=1, else 0.
  - A result transfers when res_valid[i] and res_ready[i] are both high.
  - Result valid and data stay stable until transferred.
- Throughput and latency
  - One operation per cycle when unstalled.
  - Operands accepted in cycle t appear as a result in cycle t+LAT, with no stalls.
- Simultaneous result and grant
  - A result transfer and a new grant may occur in the same cycle.
  - The multiplier register then overwrites with the new operation.
- idle = no vld bit set.
- Arithmetic: unsigned, full 2*WIDTH product; no truncation or overflow.
- Reset (reset=0, asynchronous)
  - vld clears to 0, tags clear to 0, ptr clears to 0.
  - Outputs: req_ready=0, res_valid=0, res_product=0, mul_en=1, mul_mcand=0, mul_mplier=0, idle=1.
  - Reset during an operation discards all in-flight operations; no result is produced for them after release.
  - The multiplier's internal register content is don't-care because vld gates it.
- Requester rule: the requester holds its operands stable while req_valid=1 and req_ready=0. The block does not check this.

Test Plan:
- Single op: req_valid=01, mcand0=7, mplier0=6, res_ready=11 -> req_ready=01 in cycle 0; res_valid=01 and res_product=42 in cycle 1; idle=1 in cycle 2.
- Round-robin: req_valid=11 held for 4 cycles, all products distinct -> grants alternate 01,10,01,10 starting from ptr=0; each result is tagged to the correct requester.
- Back-pressure: op for requester 1 with 0xFFFFFFFF x 0xFFFFFFFF and res_ready[1]=0 for 3 cycles -> mul_en=0, req_ready=00, and res_product=0xFFFFFFFE00000001 held stable; after res_ready=1, the result transfers in one cycle and grants resume.
- Back-to-back: requester 0 valid for 5 cycles with operands i x 3, res_ready=11 -> five grants in five consecutive cycles; results 0,3,6,9,12 each one cycle later.
- Reset mid-flight: grant op 5x5, then assert reset=0 before the result cycle -> res_valid=00 and idle=1 immediately; after release, no result is produced and ptr=0.
- Zero and edge operands: 0 x 0xFFFFFFFF -> 0; 1 x 0x80000000 -> 0x0000000080000000.

Source files
------------

// File: rtl/mult_share_ctrl.sv
// +----------------------------------------------------------------------------+
// | mult_share_ctrl : round-robin time-sharing of one pipelined multiplier      |
// |                   among NREQ valid/ready requesters, tag-tracked results.   |
// | Revision        : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module mult_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int LAT   = 1,
    parameter int TW    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_mcand,
    input  logic [NREQ*WIDTH-1:0]   req_mplier,
    output logic                    mul_en,
    output logic [WIDTH-1:0]        mul_mcand,
    output logic [WIDTH-1:0]        mul_mplier,
    input  logic [2*WIDTH-1:0]      mul_product,
    output logic [NREQ-1:0]         res_valid,
    input  logic [NREQ-1:0]         res_ready,
    output logic [2*WIDTH-1:0]      res_product,
    output logic                    idle
);

    localparam logic [TW-1:0] c_last_idx = TW'(NREQ - 1);

    logic [LAT-1:0] r_vld;
    logic [TW-1:0]  r_tag [LAT];
    logic [TW-1:0]  r_ptr;

    logic            w_stall;
    logic            w_adv;
    logic            w_gnt_any;
    logic [NREQ-1:0] w_gnt;
    logic [TW-1:0]   w_gnt_idx;
    int              w_idx;

    // Output stage decode: the tag selects which requester sees the result.
    always_comb begin
        res_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            res_valid[i] = r_vld[LAT-1] && (r_tag[LAT-1] == TW'(i));
        end
    end

    assign w_stall     = |(res_valid & ~res_ready);
    assign w_adv       = ~w_stall;
    assign mul_en      = w_adv;
    assign res_product = r_vld[LAT-1] ? mul_product : '0;
    assign idle        = ~|r_vld;

    // Grants are also masked while reset is held so req_ready reads zero.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        w_idx     = 0;
        if (w_adv && reset) begin
            for (int k = 0; k < NREQ; k++) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= NREQ) begin
                    w_idx = w_idx - NREQ;
                end
                if (!w_gnt_any && req_valid[w_idx]) begin
                    w_gnt_any    = 1'b1;
                    w_gnt[w_idx] = 1'b1;
                    w_gnt_idx    = TW'(w_idx);
                end
            end
        end
    end

    assign req_ready = w_gnt;

    always_comb begin
        mul_mcand  = '0;
        mul_mplier = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                mul_mcand  = req_mcand[i*WIDTH +: WIDTH];
                mul_mplier = req_mplier[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_tag[k] <= '0;
            end
            r_ptr <= '0;
        end else begin
            if (w_adv) begin
                r_vld[0] <= w_gnt_any;
                r_tag[0] <= w_gnt_idx;
                for (int k = 1; k < LAT; k++) begin
                    r_vld[k] <= r_vld[k-1];
                    r_tag[k] <= r_tag[k-1];
                end
            end
            if (w_gnt_any) begin
                r_ptr <= (w_gnt_idx == c_last_idx) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_share_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_mult_share_ctrl : self-checking bench with result scoreboard            |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mult_share_ctrl;

    localparam int W   = 32;
    localparam int N   = 2;
    localparam int LAT = 1;
    localparam int TW  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_mcand;
    logic [N*W-1:0]   req_mplier;
    logic             mul_en;
    logic [W-1:0]     mul_mcand;
    logic [W-1:0]     mul_mplier;
    logic [2*W-1:0]   mul_product;
    logic [N-1:0]     res_valid;
    logic [N-1:0]     res_ready;
    logic [2*W-1:0]   res_product;
    logic             idle;

    typedef struct {
        logic [N-1:0]   mask;
        logic [2*W-1:0] prod;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mult_share_ctrl #(.WIDTH(W), .NREQ(N), .LAT(LAT), .TW(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mcand  (req_mcand),
        .req_mplier (req_mplier),
        .mul_en     (mul_en),
        .mul_mcand  (mul_mcand),
        .mul_mplier (mul_mplier),
        .mul_product(mul_product),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_product(res_product),
        .idle       (idle)
    );

    // Environment model of the external pipelined multiplier.
    logic [2*W-1:0] mp [LAT];
    always @(posedge clk) begin
        if (mul_en) begin
            mp[0] <= (2*W)'(mul_mcand) * (2*W)'(mul_mplier);
            for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
        end
    end
    assign mul_product = mp[LAT-1];

    // Scoreboard: every transferred result must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && (res_valid & res_ready) != '0) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected res_valid=%b res_product=%h", res_valid, res_product);
            end else begin
                e = sb.pop_front();
                if (res_valid !== e.mask || res_product !== e.prod) begin
                    n_bad++;
                    $display("FAIL sb_result got=%b/%h exp=%b/%h", res_valid, res_product, e.mask, e.prod);
                end
            end
        end
    end

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_mcand[i*W +: W]  = a;
        req_mplier[i*W +: W] = b;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 2'b11; res_ready = 2'b11;
        set_op(0, 32'd3, 32'd4); set_op(1, 32'd5, 32'd6);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b00 || res_valid !== 2'b00 || res_product !== '0) begin
            n_bad++;
            $display("FAIL reset_io req_ready=%b res_valid=%b res_product=%h exp 00/00/0", req_ready, res_valid, res_product);
        end
        n_cmp++;
        if (mul_en !== 1'b1 || mul_mcand !== '0 || mul_mplier !== '0 || idle !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mul mul_en=%b mcand=%h mplier=%h idle=%b exp 1/0/0/1", mul_en, mul_mcand, mul_mplier, idle);
        end
        @(posedge clk); #1;
        reset = 1'b1; req_valid = '0;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        req_valid = 2'b01; set_op(0, 32'd7, 32'd6); res_ready = 2'b11;
        sb.push_back('{mask: 2'b01, prod: 64'd42});
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 2'b01 || res_product !== 64'd42) begin
            n_bad++; $display("FAIL single_result got=%b/%0d exp=01/42", res_valid, res_product);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (idle !== 1'b1) begin n_bad++; $display("FAIL single_idle got=%b exp=1", idle); end
    endtask

    task automatic test_round_robin();
        int cnt [N];
        logic [W-1:0] a [N];
        logic [N-1:0] m;
        int g;
        do_reset();
        cnt[0] = 0; cnt[1] = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            req_valid = 2'b11;
            for (int i = 0; i < N; i++) begin
                a[i] = W'(10 * i + 2 * cnt[i] + 3);
                set_op(i, a[i], a[i] + 1);
            end
            g = k % 2;
            m = 2'b01 << g;
            sb.push_back('{mask: m, prod: (2*W)'(a[g]) * (2*W)'(a[g] + 1)});
            @(negedge clk);
            n_cmp++;
            if (req_ready !== m) begin n_bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, m); end
            cnt[g]++;
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_backpressure();
        logic [2*W-1:0] big;
        big = 64'hFFFFFFFE00000001;
        do_reset();
        @(posedge clk); #1;
        req_valid = 2'b10; set_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF); res_ready = 2'b01;
        sb.push_back('{mask: 2'b10, prod: big});
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b10) begin n_bad++; $display("FAIL bp_grant got=%b exp=10", req_ready); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            req_valid = 2'b01; set_op(0, 32'd4, 32'd5);
            @(negedge clk);
            n_cmp++;
            if (mul_en !== 1'b0 || req_ready !== 2'b00 || res_valid !== 2'b10 || res_product !== big) begin
                n_bad++;
                $display("FAIL bp_stall%0d mul_en=%b req_ready=%b res_valid=%b prod=%h exp 0/00/10/%h",
                         c, mul_en, req_ready, res_valid, res_product, big);
            end
        end
        @(posedge clk); #1;
        res_ready = 2'b11;
        sb.push_back('{mask: 2'b01, prod: 64'd20});
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01 || res_valid !== 2'b10 || mul_en !== 1'b1) begin
            n_bad++; $display("FAIL bp_release req_ready=%b res_valid=%b mul_en=%b exp 01/10/1", req_ready, res_valid, mul_en);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 2'b01 || res_product !== 64'd20) begin
            n_bad++; $display("FAIL bp_next got=%b/%0d exp=01/20", res_valid, res_product);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i < 5) begin
                req_valid = 2'b01; set_op(0, W'(i), 32'd3);
                sb.push_back('{mask: 2'b01, prod: (2*W)'(3 * i)});
            end else begin
                req_valid = 2'b00;
            end
            @(negedge clk);
            if (i < 5) begin
                n_cmp++;
                if (req_ready !== 2'b01) begin n_bad++; $display("FAIL b2b_grant%0d got=%b exp=01", i, req_ready); end
            end
            if (i > 0) begin
                n_cmp++;
                if (res_valid !== 2'b01 || res_product !== (2*W)'(3 * (i - 1))) begin
                    n_bad++; $display("FAIL b2b_result%0d got=%b/%0d exp=01/%0d", i - 1, res_valid, res_product, 3 * (i - 1));
                end
            end
        end
    endtask

    task automatic test_edges();
        @(posedge clk); #1;
        req_valid = 2'b10; set_op(1, 32'd0, 32'hFFFFFFFF);
        sb.push_back('{mask: 2'b10, prod: 64'd0});
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b10) begin n_bad++; $display("FAIL edge_grant0 got=%b exp=10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b01; set_op(0, 32'd1, 32'h80000000);
        sb.push_back('{mask: 2'b01, prod: 64'h0000000080000000});
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 2'b10 || res_product !== 64'd0 || req_ready !== 2'b01) begin
            n_bad++; $display("FAIL edge_zero res=%b/%h ready=%b exp 10/0/01", res_valid, res_product, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 2'b01 || res_product !== 64'h0000000080000000) begin
            n_bad++; $display("FAIL edge_msb got=%b/%h exp=01/0000000080000000", res_valid, res_product);
        end
    endtask

    task automatic test_reset_midflight();
        @(posedge clk); #1;
        req_valid = 2'b01; set_op(0, 32'd5, 32'd5);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rstmf_grant got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (res_valid !== 2'b00 || idle !== 1'b1 || res_product !== '0) begin
            n_bad++; $display("FAIL rstmf_async res_valid=%b idle=%b prod=%h exp 00/1/0", res_valid, idle, res_product);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 2'b00 || idle !== 1'b1) begin
            n_bad++; $display("FAIL rstmf_release res_valid=%b idle=%b exp 00/1", res_valid, idle);
        end
        @(posedge clk); #1;
        req_valid = 2'b11; set_op(0, 32'd9, 32'd9); set_op(1, 32'd8, 32'd8);
        sb.push_back('{mask: 2'b01, prod: 64'd81});
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rstmf_ptr got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        req_valid  = '0;
        req_mcand  = '0;
        req_mplier = '0;
        res_ready  = 2'b11;
        reset      = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_edges();
        test_reset_midflight();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
